pc_gen: RTL and testbench

// Parametrised program-counter generator for the single-cycle RISC-V core, with fetch handshake and redirect/trap control.

---
 rtl/pc_gen.sv | 135 +++++++++++++
 tb/tb_pc_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with fetch handshake, redirect/trap and halt control
//
// Purpose: produces the instruction-fetch address for the single-cycle core.
//   The next PC is sequential, PC-relative, register-absolute (JALR-style) or a restart.
//   A redirect to a misaligned target is diverted to TRAP_VEC, and the bad target is
//   captured in epc. A one-cycle boot bubble follows reset, and halt/resume hold the PC.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active-high
//   pc_sel       00 seq, 01 pc+imm, 10 (base+imm)&~1, 11 restart
//   imm          immediate offset (already sign-extended)
//   base         rs1 value used when pc_sel=10
//   fetch_ready  fetch accepts the current pc_out this cycle
//   stall        holds the PC (blocks sequential advance only)
//   halt_req     requests entry to HALT
//   resume       leaves HALT
//   pc_out       current fetch address (registered)
//   pc_plus_inc  pc_out+INC link address (combinational)
//   pc_valid     pc_out is valid for fetch (registered)
//   misalign     one-cycle pulse after a misaligned redirect (registered)
//   epc          faulting target of the last misaligned redirect (registered)
//   halted       high while in HALT (registered)
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int              INC       = 4,
  parameter int              IALIGN    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] base,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            pc_valid,
  output logic            misalign,
  output logic [XLEN-1:0] epc,
  output logic            halted
);

  localparam logic [XLEN-1:0] INC_X = XLEN'(INC);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] target;
  logic            target_bad;

  assign pc_plus_inc = pc_out + INC_X;

  // Redirect target; the JALR form clears bit 0, so with 2-byte alignment
  // it can never be flagged as misaligned.
  always_comb begin
    target = '0;
    if (pc_sel == 2'b01) begin
      target = pc_out + imm;
    end else begin
      target = (base + imm) & ~XLEN'(1);
    end
    if (IALIGN == 4) begin
      target_bad = |target[1:0];
    end else begin
      target_bad = target[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BOOT;
      pc_out   <= RESET_VEC;
      epc      <= '0;
      misalign <= 1'b0;
      pc_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        ST_BOOT: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
          halted   <= 1'b0;
        end
        ST_RUN: begin
          if (pc_sel == 2'b11) begin
            pc_out <= RESET_VEC;
          end else if (pc_sel != 2'b00) begin
            // Redirects win over halt_req, stall and fetch_ready.
            if (target_bad) begin
              pc_out   <= TRAP_VEC;
              epc      <= target;
              misalign <= 1'b1;
            end else begin
              pc_out <= target;
            end
          end else if (halt_req) begin
            state    <= ST_HALT;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end else if (fetch_ready && !stall) begin
            pc_out <= pc_out + INC_X;
          end
        end
        ST_HALT: begin
          if (pc_sel == 2'b11) begin
            pc_out   <= RESET_VEC;
            state    <= ST_RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end else if (resume) begin
            state    <= ST_RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: begin
          state    <= ST_BOOT;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [31:0] imm;
  logic [31:0] base;
  logic        fetch_ready;
  logic        stall;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_inc;
  logic        pc_valid;
  logic        misalign;
  logic [31:0] epc;
  logic        halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .imm         (imm),
    .base        (base),
    .fetch_ready (fetch_ready),
    .stall       (stall),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc_out      (pc_out),
    .pc_plus_inc (pc_plus_inc),
    .pc_valid    (pc_valid),
    .misalign    (misalign),
    .epc         (epc),
    .halted      (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // pc, pc_valid, halted, misalign in one go
  task automatic check_st(input string tag, input logic [31:0] epc_pc, input logic v,
                          input logic h, input logic m);
    check({tag, ".pc"}, pc_out, epc_pc);
    check({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, v});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m});
  endtask

  initial begin
    rst = 1'b1; pc_sel = 2'b00; imm = '0; base = '0;
    fetch_ready = 1'b0; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
    tick(); tick();
    check_st("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.epc", epc, 32'h0);

    // Boot bubble, then sequential fetch
    rst = 1'b0; fetch_ready = 1'b1;
    tick();
    check_st("boot_exit", 32'h0, 1'b1, 1'b0, 1'b0);
    check("link0", pc_plus_inc, 32'h4);
    tick(); check("seq1", pc_out, 32'h4);
    tick(); check("seq2", pc_out, 32'h8);
    tick(); check("seq3", pc_out, 32'hC);
    stall = 1'b1;
    tick(); check("stall_hold", pc_out, 32'hC);
    stall = 1'b0; fetch_ready = 1'b0;
    tick(); check("nofetch_hold", pc_out, 32'hC);
    fetch_ready = 1'b1;
    tick(); check("seq4", pc_out, 32'h10);

    // PC-relative and JALR-style redirects
    pc_sel = 2'b01; imm = 32'hFFFF_FFF8;
    tick(); check_st("rel_back", 32'h8, 1'b1, 1'b0, 1'b0);
    pc_sel = 2'b10; base = 32'h2001; imm = 32'h2;
    tick(); check_st("jalr_trap", 32'h100, 1'b1, 1'b0, 1'b1);
    check("jalr_trap.epc", epc, 32'h2002);
    pc_sel = 2'b00; fetch_ready = 1'b0;
    tick(); check_st("trap_pulse_end", 32'h100, 1'b1, 1'b0, 1'b0);
    check("epc_kept", epc, 32'h2002);

    // Address wrap-around
    pc_sel = 2'b10; base = 32'hFFFF_FFF0; imm = 32'hC;
    tick(); check_st("jalr_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    check("link_wrap", pc_plus_inc, 32'h0);
    pc_sel = 2'b00; fetch_ready = 1'b1;
    tick(); check("seq_wrap", pc_out, 32'h0);
    tick(); check("seq_after_wrap", pc_out, 32'h4);
    pc_sel = 2'b01; imm = 32'hFFFF_FFF8;
    tick(); check_st("rel_wrap", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);

    // Halt with stall, redirect ignored while halted, resume
    pc_sel = 2'b00; stall = 1'b1; halt_req = 1'b1;
    tick(); check_st("halt_enter", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    halt_req = 1'b0; stall = 1'b0; pc_sel = 2'b01; imm = 32'h8;
    tick(); check_st("halt_ignore_rel", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    pc_sel = 2'b00; resume = 1'b1;
    tick(); check_st("resume", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    resume = 1'b0; fetch_ready = 1'b0;

    // Redirect beats a simultaneous halt request
    pc_sel = 2'b01; imm = 32'h10; halt_req = 1'b1;
    tick(); check_st("rel_over_halt", 32'hC, 1'b1, 1'b0, 1'b0);

    // Reset in HALT; boot ignores a redirect request
    pc_sel = 2'b00;
    tick(); check_st("halt_again", 32'hC, 1'b0, 1'b1, 1'b0);
    halt_req = 1'b0; rst = 1'b1;
    tick(); check_st("rst_in_halt", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; pc_sel = 2'b01; imm = 32'h40;
    tick(); check_st("boot_ignores_rel", 32'h0, 1'b1, 1'b0, 1'b0);

    // Misaligned PC-relative target traps
    imm = 32'h2;
    tick(); check_st("rel_trap", 32'h100, 1'b1, 1'b0, 1'b1);
    check("rel_trap.epc", epc, 32'h2);

    // Restart from HALT
    pc_sel = 2'b00; fetch_ready = 1'b1;
    tick(); check("seq_from_trap", pc_out, 32'h104);
    fetch_ready = 1'b0; halt_req = 1'b1;
    tick(); check_st("halt3", 32'h104, 1'b0, 1'b1, 1'b0);
    halt_req = 1'b0; pc_sel = 2'b11;
    tick(); check_st("restart_from_halt", 32'h0, 1'b1, 1'b0, 1'b0);

    // Restart from RUN
    pc_sel = 2'b00; fetch_ready = 1'b1;
    tick(); check("seq5", pc_out, 32'h4);
    pc_sel = 2'b11;
    tick(); check_st("restart_run", 32'h0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
